seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential unsigned restoring divider; the inverse of the team's cfq multiplier.
//  Accepts an 8-bit dividend and a 4-bit divisor on a start pulse.
//  Produces one quotient bit per clock and returns quotient and remainder with a done pulse.
//  Sits beside the multiplier in the arithmetic lesson datapath.
// PARAMETERS
//  DW  8  dividend/quotient width; also the iteration count
//  VW  4  divisor/remainder width (VW <= DW)
// PORTS
//  clk        in   1   system clock, rising-edge
//  rst        in   1   asynchronous active-low reset (0 = reset)
//  start      in   1   request; sampled on rising clk while ready
//  a          in   DW  dividend, captured when start is accepted
//  b          in   VW  divisor, captured when start is accepted
//  ready      out  1   1 in IDLE or DONE: start will be accepted
//  busy       out  1   1 while iterating (state BUSY)
//  done       out  1   one-cycle pulse: results valid
//  quotient   out  DW  a / b; held until next completion
//  remainder  out  VW  a % b; held until next completion
//  dz         out  1   divide-by-zero flag for the last result; held
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; quotient=0, remainder=0, dz=0, done=0, busy=0, ready=1.
//  FSM states:
//   IDLE -> BUSY on start. Latch a, b; clear the partial remainder (VW+1 bits); cnt=0.
//   IDLE: start=0 -> stays IDLE.
//   BUSY, each edge:
//    - pr = {pr[VW-1:0], dividend MSB}; shift the dividend left.
//    - if pr >= {1'b0,b}: pr -= b and the quotient bit = 1; else the quotient bit = 0.
//    - cnt++.
//   BUSY: after DW iterations (cnt==DW-1 at the edge) -> DONE.
//    Register quotient and remainder=pr[VW-1:0]; dz=0.
//   BUSY with b==0 latched -> DONE on the first BUSY edge. No iterations.
//    quotient={DW{1'b1}}, remainder=a[VW-1:0], dz=1.
//   DONE: done=1 for exactly this cycle.
//    start=1 -> BUSY, back-to-back with new operands latched.
//    Otherwise -> IDLE.
//  Latency: start accepted at edge N -> done high during the cycle after edge N+DW (b!=0).
//   With b==0, done follows edge N+1.
//  Start while BUSY: ignored. Latched operands and progress are unaffected.
//  a, b changing while BUSY: no effect; only the values at acceptance are used.
//  Outputs change only on entry to DONE or on reset.
//   The previous result stays visible during a new BUSY phase.
//  Partial remainder is VW+1 bits wide so the compare never overflows.
//  Remainder is always < b. Quotient fits DW bits for every b>=1.
//  Reset mid-operation: the async clear aborts at once. No done pulse.
//   After reset release the block is IDLE and ready.
//  busy and done are never high together. ready = ~busy.
// TESTING
//  1. a=31 (8'h1F), b=2: start -> done 9 cycles later; quotient=15, remainder=1, dz=0.
//  2. a=29 (8'h1D), b=3 back-to-back from DONE: quotient=9, remainder=2, no IDLE cycle.
//  3. Boundaries:
//   a=255, b=15 -> 17 r0.
//   a=7, b=9 -> 0 r7.
//   a=0, b=1 -> 0 r0.
//   a=255, b=1 -> 255 r0.
//  4. a=100, b=0: done 2 cycles after start; quotient=255, remainder=4, dz=1.
//   A following 100/7 gives quotient=14, remainder=2, dz=0.
//  5. Pulse start (a=50, b=5) mid-BUSY of 200/3: result stays 66 r2.
//   The second start is lost. Busy length stays 8 cycles.
//  6. Assert rst=0 at iteration 4 of 31/2:
//   All outputs 0 asynchronously; no done pulse.
//   After release, 31/2 completes with 15 r1.
//  Every case: a self-check compares against a/b and a%b.
//   The bench runs a random sweep of 500 operand pairs, b=0 included.

Source files
------------

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done follows the start edge by DW cycles (1 if b==0).
// No backpressure: start is taken whenever ready, ignored while busy; results hold until the next completion.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW-1:0] r_pr;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dz;

    logic [VW:0]   w_pr_shift;
    logic [VW:0]   w_diff;
    logic          w_qbit;
    logic [VW-1:0] w_pr_next;
    logic          w_accept;
    logic          w_zero;
    logic          w_last;

    // The trial subtract is VW+1 wide; its top bit is the borrow, so no borrow means pr >= b.
    always_comb begin
        w_pr_shift = {r_pr, r_dvd[DW-1]};
        w_diff     = w_pr_shift - {1'b0, r_dvs};
        w_qbit     = ~w_diff[VW];
        w_pr_next  = w_qbit ? w_diff[VW-1:0] : w_pr_shift[VW-1:0];
        w_accept   = start && (r_state != BUSY);
        w_zero     = (r_dvs == '0);
        w_last     = (r_cnt == CW'(DW - 1));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = BUSY;
            BUSY:    if (w_zero || w_last) w_next = DONE;
            DONE:    w_next = start ? BUSY : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_pr   <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= a;
            r_dvs <= b;
            r_pr  <= '0;
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            if (w_zero) begin
                r_quot <= '1;
                r_rem  <= r_dvd[VW-1:0];
                r_dz   <= 1'b1;
            end else begin
                // Quotient bits shift into the vacated low end of the dividend register.
                r_dvd <= {r_dvd[DW-2:0], w_qbit};
                r_pr  <= w_pr_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_quot <= {r_dvd[DW-2:0], w_qbit};
                    r_rem  <= w_pr_next;
                    r_dz   <= 1'b0;
                end
            end
        end
    end

    assign busy      = (r_state == BUSY);
    assign ready     = ~busy;
    assign done      = (r_state == DONE);
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dz        = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: transaction-level model plus directed literal cases and a random sweep.
module tb_seq_divider;

    localparam int DW = 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dz;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted job is busy for a fixed number of cycles, then publishes a/b, a%b.
    int         m_left = 0;
    bit         m_done = 0;
    logic [7:0] m_q    = 0;
    logic [3:0] m_r    = 0;
    bit         m_dz   = 0;
    logic [7:0] p_q;
    logic [3:0] p_r;
    bit         p_dz;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0;
            m_done = 0;
            m_q    = 0;
            m_r    = 0;
            m_dz   = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_q    = p_q;
                m_r    = p_r;
                m_dz   = p_dz;
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_left = (b == 0) ? 1 : DW;
                p_q    = (b == 0) ? 8'hFF : a / 8'(b);
                p_r    = (b == 0) ? a[3:0] : 4'(a % 8'(b));
                p_dz   = (b == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_done", int'(done), int'(m_done));
            chk("cyc_busy", int'(busy), int'(m_left > 0));
            chk("cyc_ready", int'(ready), int'(m_left == 0));
            chk("cyc_quotient", int'(quotient), int'(m_q));
            chk("cyc_remainder", int'(remainder), int'(m_r));
            chk("cyc_dz", int'(dz), int'(m_dz));
            chk("cyc_busy_done_excl", int'(busy && done), 0);
        end
    end

    // Called at a negedge; returns at the negedge where done is seen (so a call right after is back-to-back).
    task automatic do_op(input logic [7:0] ta, input logic [3:0] tb_b, input int eq, input int er,
                         input int edz, input bit noise, input int pulse_k);
        int lat;
        int got;
        lat = (tb_b == 0) ? 1 : DW;
        got = -1;
        a = ta;
        b = tb_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noise) begin
            a = 8'($urandom);
            b = 4'($urandom);
        end
        for (int k = 0; k <= lat + 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_after_accept", int'(busy), 1);
            if (done) begin
                got = k;
                break;
            end
            if (k == pulse_k) begin
                start = 1'b1;
                a = 8'd50;
                b = 4'd5;
            end else if (k == pulse_k + 1) begin
                start = 1'b0;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a = 8'($urandom);
                b = 4'($urandom);
            end
        end
        start = 1'b0;
        if (got < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout a=%0d b=%0d no done within %0d cycles", ta, tb_b, lat + 5);
        end else begin
            chk("latency", got, lat);
            chk("quotient", int'(quotient), eq);
            chk("remainder", int'(remainder), er);
            chk("dz", int'(dz), edz);
        end
    endtask

    logic [7:0] ra;
    logic [3:0] rb;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dz", int'(dz), 0);
        chk_en = 1;
        #2 rst = 1'b1;
        @(negedge clk);

        do_op(8'd31, 4'd2, 15, 1, 0, 0, -1);
        do_op(8'd29, 4'd3, 9, 2, 0, 0, -1);
        @(negedge clk);
        do_op(8'd255, 4'd15, 17, 0, 0, 0, -1);
        do_op(8'd7, 4'd9, 0, 7, 0, 0, -1);
        do_op(8'd0, 4'd1, 0, 0, 0, 0, -1);
        do_op(8'd255, 4'd1, 255, 0, 0, 0, -1);
        @(negedge clk);
        do_op(8'd100, 4'd0, 255, 4, 1, 0, -1);
        do_op(8'd100, 4'd7, 14, 2, 0, 0, -1);
        @(negedge clk);

        do_op(8'd200, 4'd3, 66, 2, 0, 0, 3);
        @(negedge clk);
        chk("lost_start_idle", int'(busy), 0);

        a = 8'd31;
        b = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_quotient", int'(quotient), 0);
        chk("arst_remainder", int'(remainder), 0);
        chk("arst_dz", int'(dz), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(ready), 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(ready), 1);
        do_op(8'd31, 4'd2, 15, 1, 0, 0, -1);

        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom);
            rb = 4'($urandom);
            if (i % 10 == 0) rb = 4'd0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(ra, rb, (rb == 0) ? 255 : int'(ra) / int'(rb),
                  (rb == 0) ? int'(ra[3:0]) : int'(ra) % int'(rb),
                  (rb == 0) ? 1 : 0, 1, -1);
        end

        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
